// File: rtl/letter_burst_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : letter_burst_arbiter_if
// Brief    : Requester bus, memory address beat and aligned response group
// Revision : 1.0
// ============================================================================
interface letter_burst_arbiter_if #(
  parameter int WORDINDEXBITS   = 7,
  parameter int LETTERINDEXBITS = 3,
  parameter int NUM_REQ         = 4,
  parameter int ID_BITS         = 2
);
  localparam int ADDR_W = WORDINDEXBITS + LETTERINDEXBITS;

  logic [NUM_REQ-1:0]                 req;
  logic [NUM_REQ*ADDR_W-1:0]          req_addr;
  logic [NUM_REQ*LETTERINDEXBITS-1:0] req_len;
  logic                               mem_busy;

  logic [NUM_REQ-1:0]                 grant;
  logic [ADDR_W-1:0]                  mem_address;
  logic                               mem_valid;
  logic [ID_BITS-1:0]                 mem_id;
  logic                               mem_last;

  logic                               resp_valid;
  logic [ID_BITS-1:0]                 resp_id;
  logic                               resp_last;

  modport master (
    output req, req_addr, req_len, mem_busy,
    input  grant, mem_address, mem_valid, mem_id, mem_last,
    input  resp_valid, resp_id, resp_last
  );

  modport slave (
    input  req, req_addr, req_len, mem_busy,
    output grant, mem_address, mem_valid, mem_id, mem_last,
    output resp_valid, resp_id, resp_last
  );
endinterface
`default_nettype wire

// File: rtl/letter_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : letter_burst_arbiter
// Brief    : Round-robin letter-burst arbiter with latency-matched response line
// Revision : 1.0
// ============================================================================
module letter_burst_arbiter #(
  parameter int WORDINDEXBITS   = 7,
  parameter int LETTERINDEXBITS = 3,
  parameter int NUM_REQ         = 4,
  parameter int ID_BITS         = 2,
  parameter int READ_LATENCY    = 2
) (
  input  wire logic              clock,
  input  wire logic              reset,
  letter_burst_arbiter_if.slave  bus
);

  localparam int ADDR_W = WORDINDEXBITS + LETTERINDEXBITS;
  localparam int DLY_W  = ID_BITS + 2;
  localparam logic [LETTERINDEXBITS-1:0] c_len_zero   = '0;
  localparam logic [LETTERINDEXBITS-1:0] c_len_one    = LETTERINDEXBITS'(1);
  localparam logic [ID_BITS-1:0]         c_lw_reset   = ID_BITS'(NUM_REQ - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                       r_state;
  logic [NUM_REQ-1:0]           r_grant;
  logic [ADDR_W-1:0]            r_addr;
  logic                         r_valid;
  logic [ID_BITS-1:0]           r_id;
  logic                         r_last;
  logic [LETTERINDEXBITS-1:0]   r_count;
  logic [ID_BITS-1:0]           r_last_winner;
  logic [DLY_W-1:0]             r_dly [READ_LATENCY];

  state_t                       w_state_nxt;
  logic [NUM_REQ-1:0]           w_grant_nxt;
  logic [ADDR_W-1:0]            w_addr_nxt;
  logic                         w_valid_nxt;
  logic [ID_BITS-1:0]           w_id_nxt;
  logic                         w_last_nxt;
  logic [LETTERINDEXBITS-1:0]   w_count_nxt;
  logic [ID_BITS-1:0]           w_lw_nxt;

  logic                         w_found;
  logic [ID_BITS-1:0]           w_win_id;
  logic [NUM_REQ-1:0]           w_win_onehot;
  logic [ADDR_W-1:0]            w_win_addr;
  logic [LETTERINDEXBITS-1:0]   w_win_len;
  logic [LETTERINDEXBITS-1:0]   w_letter_inc;

  // Round-robin: first scan above the last winner, then wrap to the bottom.
  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && bus.req[i] && (i > int'(r_last_winner))) begin
        w_found  = 1'b1;
        w_win_id = ID_BITS'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && bus.req[i] && (i <= int'(r_last_winner))) begin
        w_found  = 1'b1;
        w_win_id = ID_BITS'(i);
      end
    end
  end

  always_comb begin
    w_win_onehot = '0;
    w_win_addr   = '0;
    w_win_len    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win_id == ID_BITS'(i)) begin
        w_win_onehot[i] = 1'b1;
        w_win_addr      = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_win_len       = bus.req_len[i*LETTERINDEXBITS +: LETTERINDEXBITS];
      end
    end
  end

  // Letter field wraps within the word; the word field never takes a carry.
  assign w_letter_inc = r_addr[LETTERINDEXBITS-1:0] + c_len_one;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = '0;
    w_addr_nxt  = r_addr;
    w_valid_nxt = 1'b0;
    w_id_nxt    = r_id;
    w_last_nxt  = r_last;
    w_count_nxt = r_count;
    w_lw_nxt    = r_last_winner;

    case (r_state)
      S_IDLE: begin
        w_last_nxt = 1'b0;
        if (!bus.mem_busy && w_found) begin
          w_grant_nxt = w_win_onehot;
          w_addr_nxt  = w_win_addr;
          w_valid_nxt = 1'b1;
          w_id_nxt    = w_win_id;
          w_lw_nxt    = w_win_id;
          w_count_nxt = w_win_len;
          w_last_nxt  = (w_win_len == c_len_zero);
          w_state_nxt = (w_win_len == c_len_zero) ? S_IDLE : S_BURST;
        end
      end
      S_BURST: begin
        if (!bus.mem_busy) begin
          w_addr_nxt  = {r_addr[ADDR_W-1:LETTERINDEXBITS], w_letter_inc};
          w_count_nxt = r_count - c_len_one;
          w_valid_nxt = 1'b1;
          if (r_count == c_len_one) begin
            w_last_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_addr        <= '0;
      r_valid       <= 1'b0;
      r_id          <= '0;
      r_last        <= 1'b0;
      r_count       <= '0;
      r_last_winner <= c_lw_reset;
    end else begin
      r_state       <= w_state_nxt;
      r_grant       <= w_grant_nxt;
      r_addr        <= w_addr_nxt;
      r_valid       <= w_valid_nxt;
      r_id          <= w_id_nxt;
      r_last        <= w_last_nxt;
      r_count       <= w_count_nxt;
      r_last_winner <= w_lw_nxt;
    end
  end

  // Response line shifts unconditionally so it stays aligned with read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_dly[i] <= '0;
      end
    end else begin
      r_dly[0] <= {r_valid, r_id, r_last};
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_dly[i] <= r_dly[i-1];
      end
    end
  end

  assign bus.grant       = r_grant;
  assign bus.mem_address = r_addr;
  assign bus.mem_valid   = r_valid;
  assign bus.mem_id      = r_id;
  assign bus.mem_last    = r_last;
  assign bus.resp_valid  = r_dly[READ_LATENCY-1][DLY_W-1];
  assign bus.resp_id     = r_dly[READ_LATENCY-1][ID_BITS:1];
  assign bus.resp_last   = r_dly[READ_LATENCY-1][0];

endmodule
`default_nettype wire

// File: tb/tb_letter_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_letter_burst_arbiter
// Brief    : Directed self-checking bench for letter_burst_arbiter
// Revision : 1.0
// ============================================================================
module tb_letter_burst_arbiter;

  localparam int WB = 7;
  localparam int LB = 3;
  localparam int NR = 4;
  localparam int IB = 2;
  localparam int RL = 2;
  localparam int AW = WB + LB;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  letter_burst_arbiter_if #(
    .WORDINDEXBITS(WB), .LETTERINDEXBITS(LB), .NUM_REQ(NR), .ID_BITS(IB)
  ) bus ();

  letter_burst_arbiter #(
    .WORDINDEXBITS(WB), .LETTERINDEXBITS(LB), .NUM_REQ(NR), .ID_BITS(IB),
    .READ_LATENCY(RL)
  ) u_dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int mk(input int word, input int letter);
    return word * (1 << LB) + letter;
  endfunction

  task automatic set_slot(input int i, input int word, input int letter, input int len);
    bus.req_addr[i*AW +: AW] = AW'(mk(word, letter));
    bus.req_len[i*LB +: LB]  = LB'(len);
  endtask

  task automatic check_beat(input string tag, input int g, input int a, input int v,
                            input int id, input int l);
    check({tag, ".grant"}, 32'(bus.grant), g);
    check({tag, ".addr"},  32'(bus.mem_address), a);
    check({tag, ".valid"}, 32'(bus.mem_valid), v);
    check({tag, ".id"},    32'(bus.mem_id), id);
    check({tag, ".last"},  32'(bus.mem_last), l);
  endtask

  task automatic check_resp(input string tag, input int v, input int id, input int l);
    check({tag, ".rvalid"}, 32'(bus.resp_valid), v);
    check({tag, ".rid"},    32'(bus.resp_id), id);
    check({tag, ".rlast"},  32'(bus.resp_last), l);
  endtask

  int t2_letters [4] = '{6, 7, 0, 1};
  int t4_busy    [7] = '{0, 1, 1, 0, 0, 0, 0};
  int t4_valid   [7] = '{1, 0, 0, 1, 1, 0, 0};
  int t4_letter  [7] = '{2, 2, 2, 3, 4, 4, 4};
  int t4_last    [7] = '{0, 0, 0, 0, 1, 0, 0};
  int t4_rvalid  [7] = '{0, 0, 1, 0, 0, 1, 1};
  int t4_rlast   [7] = '{0, 0, 0, 0, 0, 0, 1};

  initial begin
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_len  = '0;
    bus.mem_busy = 1'b0;
    tick();
    tick();
    check_beat("rst", 0, 0, 0, 0, 0);
    check_resp("rst", 0, 0, 0);

    // Single-beat burst; response trails by the read latency.
    set_slot(0, 5, 0, 0);
    bus.req = 4'b0001;
    rst     = 1'b0;
    tick();
    check_beat("t1", 1, 'h28, 1, 0, 1);
    bus.req = '0;
    tick();
    check("t1.idle_valid", 32'(bus.mem_valid), 0);
    check("t1.idle_grant", 32'(bus.grant), 0);
    check("t1.early_resp", 32'(bus.resp_valid), 0);
    tick();
    check_resp("t1.resp", 1, 0, 1);
    tick();
    check("t1.resp_end", 32'(bus.resp_valid), 0);

    // Four-beat burst wrapping the letter field inside word 9.
    set_slot(0, 9, 6, 3);
    bus.req = 4'b0001;
    for (int b = 0; b < 4; b++) begin
      tick();
      check_beat($sformatf("t2.b%0d", b), (b == 0) ? 1 : 0, mk(9, t2_letters[b]), 1, 0,
                 (b == 3) ? 1 : 0);
      if (b == 0) bus.req = '0;
    end
    tick();
    check("t2.after_valid", 32'(bus.mem_valid), 0);
    check("t2.after_last",  32'(bus.mem_last), 0);

    // Round-robin rotation with all requesters continuously asking.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) set_slot(i, i + 1, i, 0);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_beat($sformatf("t3.k%0d", k), 1 << (k % NR), mk((k % NR) + 1, k % NR), 1,
                 k % NR, 1);
    end
    bus.req = '0;
    tick();
    tick();

    // Three-beat burst stalled for two cycles after its first beat.
    set_slot(1, 3, 2, 2);
    bus.req = 4'b0010;
    for (int k = 0; k < 7; k++) begin
      bus.mem_busy = t4_busy[k][0];
      tick();
      if (k == 0) begin
        check("t4.grant", 32'(bus.grant), 2);
        bus.req = '0;
      end
      check($sformatf("t4.valid%0d", k), 32'(bus.mem_valid), t4_valid[k]);
      if (t4_valid[k] != 0) begin
        check($sformatf("t4.addr%0d", k), 32'(bus.mem_address), mk(3, t4_letter[k]));
        check($sformatf("t4.id%0d", k), 32'(bus.mem_id), 1);
      end
      check($sformatf("t4.last%0d", k), 32'(bus.mem_last), t4_last[k]);
      check($sformatf("t4.rvalid%0d", k), 32'(bus.resp_valid), t4_rvalid[k]);
      check($sformatf("t4.rlast%0d", k), 32'(bus.resp_last), t4_rlast[k]);
      if (t4_rvalid[k] != 0) check($sformatf("t4.rid%0d", k), 32'(bus.resp_id), 1);
    end

    // Reset during the second beat of an eight-beat burst.
    set_slot(0, 1, 0, 7);
    set_slot(1, 6, 3, 0);
    bus.req = 4'b0001;
    tick();
    check_beat("t5.b0", 1, mk(1, 0), 1, 0, 0);
    bus.req = 4'b0110;
    tick();
    check_beat("t5.b1", 0, mk(1, 1), 1, 0, 0);
    rst = 1'b1;
    tick();
    check_beat("t5.rst", 0, 0, 0, 0, 0);
    check_resp("t5.rst", 0, 0, 0);
    rst = 1'b0;
    tick();
    check_beat("t5.next", 2, mk(6, 3), 1, 1, 1);
    check("t5.nresp0", 32'(bus.resp_valid), 0);
    bus.req = '0;
    tick();
    check("t5.nresp1", 32'(bus.resp_valid), 0);
    tick();
    check_resp("t5.resp", 1, 1, 1);

    // Back-to-back bursts: requester 1 follows requester 0 with no bubble.
    set_slot(0, 2, 7, 1);
    set_slot(1, 4, 1, 0);
    bus.req = 4'b0011;
    tick();
    check_beat("t6.a", 1, mk(2, 7), 1, 0, 0);
    bus.req = 4'b0010;
    tick();
    check_beat("t6.b", 0, mk(2, 0), 1, 0, 1);
    tick();
    check_beat("t6.c", 2, mk(4, 1), 1, 1, 1);
    bus.req = '0;
    tick();
    check("t6.d_valid", 32'(bus.mem_valid), 0);
    check("t6.d_grant", 32'(bus.grant), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
